// File: rtl/rv32i_pkg.sv
// +---------------------------------------------------------------------------+
// | rv32i_pkg : shared widths and writeback types for the RV32I core slice     |
// | Revision  : 1.0                                                            |
// +---------------------------------------------------------------------------+
`default_nettype none

package rv32i_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = $clog2(NREG);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/rf_wb_sched_if.sv
// +---------------------------------------------------------------------------+
// | rf_wb_sched_if : issue, writeback-source and regfile-port bundle           |
// | Revision       : 1.0                                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

interface rf_wb_sched_if;
    import rv32i_pkg::*;

    logic                 issue_valid;
    logic                 issue_we;
    logic [REG_IDX_W-1:0] issue_rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rs1_busy;
    logic                 rs2_busy;

    logic                 alu_valid;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]      alu_data;
    logic                 alu_ready;

    logic                 lsu_valid;
    logic [REG_IDX_W-1:0] lsu_rd;
    logic [XLEN-1:0]      lsu_data;
    logic                 lsu_ready;

    logic                 rf_write_en;
    logic [REG_IDX_W-1:0] rf_write_reg;
    logic [XLEN-1:0]      rf_write_data;

    logic                 fwd_a_valid;
    logic                 fwd_b_valid;
    logic [XLEN-1:0]      fwd_data;
    logic                 wb_unexpected;

    // Scheduler side.
    modport slave (
        input  issue_valid, issue_we, issue_rd, rs1, rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output rs1_busy, rs2_busy, alu_ready, lsu_ready,
        output rf_write_en, rf_write_reg, rf_write_data,
        output fwd_a_valid, fwd_b_valid, fwd_data, wb_unexpected
    );

    // Pipeline / stimulus side.
    modport master (
        output issue_valid, issue_we, issue_rd, rs1, rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  rs1_busy, rs2_busy, alu_ready, lsu_ready,
        input  rf_write_en, rf_write_reg, rf_write_data,
        input  fwd_a_valid, fwd_b_valid, fwd_data, wb_unexpected
    );

endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// +---------------------------------------------------------------------------+
// | rr_arb2 : two-requester round-robin arbiter (ALU vs LSU)                   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module rr_arb2
    import rv32i_pkg::*;
(
    input  wire  clk,
    input  wire  reset,
    input  logic req_alu,
    input  logic req_lsu,
    output logic gnt_alu,
    output logic gnt_lsu
);

    wb_src_e r_last_grant;

    // Under contention the source that lost last time wins now.
    assign gnt_alu = req_alu && (!req_lsu || (r_last_grant == SRC_LSU));
    assign gnt_lsu = req_lsu && (!req_alu || (r_last_grant == SRC_ALU));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= SRC_ALU;
        end else if (gnt_alu || gnt_lsu) begin
            r_last_grant <= gnt_lsu ? SRC_LSU : SRC_ALU;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_wb_sched.sv
// +---------------------------------------------------------------------------+
// | rf_wb_sched : regfile writeback arbiter, busy scoreboard and forwarding    |
// | Revision    : 1.0                                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module rf_wb_sched
    import rv32i_pkg::*;
(
    input  wire          clk,
    input  wire          reset,
    rf_wb_sched_if.slave bus
);

    wb_req_t              w_alu_req;
    wb_req_t              w_lsu_req;
    wb_req_t              w_sel_req;
    logic                 w_gnt_alu;
    logic                 w_gnt_lsu;
    logic                 w_accept;
    logic                 w_rd_nonzero;
    logic [NREG-1:0]      w_busy_next;

    logic [NREG-1:0]      r_busy;
    logic                 r_write_en;
    logic [REG_IDX_W-1:0] r_write_reg;
    logic [XLEN-1:0]      r_write_data;
    logic                 r_fwd_a_valid;
    logic                 r_fwd_b_valid;
    logic [XLEN-1:0]      r_fwd_data;
    logic                 r_wb_unexpected;

    assign w_alu_req = '{valid: bus.alu_valid, rd: bus.alu_rd, data: bus.alu_data};
    assign w_lsu_req = '{valid: bus.lsu_valid, rd: bus.lsu_rd, data: bus.lsu_data};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_alu (w_alu_req.valid),
        .req_lsu (w_lsu_req.valid),
        .gnt_alu (w_gnt_alu),
        .gnt_lsu (w_gnt_lsu)
    );

    assign bus.alu_ready = w_gnt_alu;
    assign bus.lsu_ready = w_gnt_lsu;

    assign w_accept     = w_gnt_alu || w_gnt_lsu;
    assign w_sel_req    = w_gnt_lsu ? w_lsu_req : w_alu_req;
    assign w_rd_nonzero = (w_sel_req.rd != '0);

    // A same-cycle issue to the register being retired re-arms it: the new producer owns it.
    always_comb begin
        w_busy_next = r_busy;
        if (w_accept) begin
            w_busy_next[w_sel_req.rd] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_we) begin
            w_busy_next[bus.issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy          <= '0;
            r_write_en      <= 1'b0;
            r_write_reg     <= '0;
            r_write_data    <= '0;
            r_fwd_a_valid   <= 1'b0;
            r_fwd_b_valid   <= 1'b0;
            r_fwd_data      <= '0;
            r_wb_unexpected <= 1'b0;
        end else begin
            r_busy          <= w_busy_next;
            r_write_en      <= w_accept && w_rd_nonzero;
            r_wb_unexpected <= w_accept && w_rd_nonzero && !r_busy[w_sel_req.rd];
            if (w_accept) begin
                r_write_reg  <= w_sel_req.rd;
                r_write_data <= w_sel_req.data;
            end
            // regfile reads return pre-write data, so the write in flight is replayed next cycle.
            r_fwd_a_valid <= r_write_en && (r_write_reg == bus.rs1);
            r_fwd_b_valid <= r_write_en && (r_write_reg == bus.rs2);
            r_fwd_data    <= r_write_data;
        end
    end

    assign bus.rs1_busy      = r_busy[bus.rs1];
    assign bus.rs2_busy      = r_busy[bus.rs2];
    assign bus.rf_write_en   = r_write_en;
    assign bus.rf_write_reg  = r_write_reg;
    assign bus.rf_write_data = r_write_data;
    assign bus.fwd_a_valid   = r_fwd_a_valid;
    assign bus.fwd_b_valid   = r_fwd_b_valid;
    assign bus.fwd_data      = r_fwd_data;
    assign bus.wb_unexpected = r_wb_unexpected;

endmodule

`default_nettype wire
